// File: rtl/booth_mult_32_pkg.sv
// rtl/booth_mult_32_pkg.sv - shared constants and types for the radix-2 Booth multiplier
package booth_mult_32_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } stateT;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Carry into the MSB is recovered from the MSB sum bit; overflow is that carry vs. carry out.
  function automatic logic addSubOverflow(
    input logic aMsb,
    input logic bEffMsb,
    input logic yMsb,
    input logic carryOut
  );
    return (aMsb ^ bEffMsb ^ yMsb) ^ carryOut;
  endfunction

endpackage

// File: rtl/booth_mult_32_add_sub.sv
// rtl/booth_mult_32_add_sub.sv - 32-bit ripple-carry adder/subtractor (SnA=1 gives A-B)
module RC_ADD_SUB_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SnA,
  output logic [31:0] Y,
  output logic        CO
);

  logic [32:0] carry;
  logic [31:0] bEff;

  always_comb begin
    carry    = '0;
    bEff     = B ^ {32{SnA}};
    Y        = '0;
    carry[0] = SnA;
    for (int i = 0; i < 32; i++) begin
      Y[i]       = A[i] ^ bEff[i] ^ carry[i];
      carry[i+1] = (A[i] & bEff[i]) | (A[i] & carry[i]) | (bEff[i] & carry[i]);
    end
    CO = carry[32];
  end

endmodule

// File: rtl/booth_mult_32.sv
// rtl/booth_mult_32.sv - sequential signed 32x32 multiplier, one Booth step per cycle
module booth_mult_32
  import booth_mult_32_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] MCND,
  input  logic [WIDTH-1:0] MPLR,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] mReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] qReg;
  logic             qm1;
  logic [5:0]       cnt;

  logic             load;
  logic             step;
  logic [1:0]       boothSel;
  logic             useAdder;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             ovf;
  logic [WIDTH-1:0] stepS;
  logic             sgn;

  assign boothSel = {qReg[0], qm1};

  // Q[0] alone picks add vs subtract; the result is only used when boothSel is 01 or 10.
  RC_ADD_SUB_32 uAddSub (
    .A   (aReg),
    .B   (mReg),
    .SnA (qReg[0]),
    .Y   (sum),
    .CO  (carryOut)
  );

  always_comb begin
    useAdder = (boothSel == BOOTH_ADD) || (boothSel == BOOTH_SUB);
    ovf      = addSubOverflow(aReg[WIDTH-1], mReg[WIDTH-1] ^ qReg[0], sum[WIDTH-1], carryOut);
    stepS    = useAdder ? sum : aReg;
    // The true sign of A+/-M survives an overflow, which keeps M = 0x8000_0000 exact.
    sgn      = useAdder ? (stepS[WIDTH-1] ^ ovf) : aReg[WIDTH-1];
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          load      = 1'b1;
          stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mReg <= '0;
      aReg <= '0;
      qReg <= '0;
      qm1  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      mReg <= MCND;
      aReg <= '0;
      qReg <= MPLR;
      qm1  <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      aReg <= {sgn, stepS[WIDTH-1:1]};
      qReg <= {stepS[0], qReg[WIDTH-1:1]};
      qm1  <= qReg[0];
      cnt  <= cnt + 6'd1;
    end
  end

  assign HI   = aReg;
  assign LO   = qReg;
  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_booth_mult_32.sv
// tb/tb_booth_mult_32.sv - directed self-checking bench for booth_mult_32
module tb_booth_mult_32;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] MCND;
  logic [31:0] MPLR;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;

  int checkCnt;
  int passCnt;

  booth_mult_32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .MCND  (MCND),
    .MPLR  (MPLR),
    .HI    (HI),
    .LO    (LO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply; optionally pulse a stray START with other operands at cycle interferAt.
  task automatic runMult(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                         input logic [31:0] expHi, input logic [31:0] expLo, input int interferAt);
    int cyc;
    int doneCnt;
    @(negedge CLK);
    MCND  = mc;
    MPLR  = mp;
    START = 1'b1;
    @(posedge CLK);
    cyc = 0;
    doneCnt = 0;
    while (cyc < 40 && doneCnt == 0) begin
      @(negedge CLK);
      cyc++;
      START = (cyc == interferAt);
      if (cyc == interferAt) begin
        MCND = 32'd9;
        MPLR = 32'd9;
      end
      if (cyc == 1) checkVal({tag, " busy"}, {63'd0, BUSY}, 64'd1);
      if (DONE) doneCnt++;
    end
    checkVal({tag, " latency"}, 64'(cyc), 64'd33);
    checkVal({tag, " product"}, {HI, LO}, {expHi, expLo});
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (DONE) doneCnt++;
    end
    checkVal({tag, " done pulses"}, 64'(doneCnt), 64'd1);
    checkVal({tag, " hold"}, {HI, LO}, {expHi, expLo});
    checkVal({tag, " idle"}, {62'd0, BUSY, DONE}, 64'd0);
  endtask

  initial begin
    int cyc;
    int doneCnt;
    checkCnt = 0;
    passCnt  = 0;
    RST   = 1'b0;
    START = 1'b0;
    MCND  = 32'd0;
    MPLR  = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkVal("reset outputs", {HI, LO}, 64'd0);
    checkVal("reset flags", {62'd0, BUSY, DONE}, 64'd0);
    RST = 1'b1;

    runMult("3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 0);
    runMult("-1x1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    runMult("min x min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    runMult("max x max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
    runMult("-7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
    runMult("min x -1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    // 100 * -3 = -300, with a stray START mid-run
    runMult("ignored start", 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FED4, 10);

    // Reset during RUN abandons the multiply
    @(negedge CLK);
    MCND  = 32'd12345;
    MPLR  = 32'd678;
    START = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    RST = 1'b0;
    @(negedge CLK);
    checkVal("midrun reset outputs", {HI, LO}, 64'd0);
    checkVal("midrun reset flags", {62'd0, BUSY, DONE}, 64'd0);
    RST = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) doneCnt++;
    end
    checkVal("no done after reset", 64'(doneCnt), 64'd0);
    runMult("2x-4", 32'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 0);

    // START held high: DONE-to-DONE spacing equals the minimum issue interval
    @(negedge CLK);
    MCND  = 32'd3;
    MPLR  = 32'd5;
    START = 1'b1;
    cyc = 0;
    while (cyc < 40 && !DONE) begin
      @(negedge CLK);
      cyc++;
    end
    checkVal("b2b first done", {63'd0, DONE}, 64'd1);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (cyc < 40 && !DONE);
    checkVal("b2b interval", 64'(cyc), 64'd34);
    checkVal("b2b product", {HI, LO}, 64'd15);
    START = 1'b0;
    repeat (40) @(negedge CLK);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
